// File: rtl/rom_sram_ctrl.sv
// rtl/rom_sram_ctrl.sv - PC-side fetch/ROM responder driving a 32-bit asynchronous SRAM
//
// Runs one multi-cycle SRAM access per PC request and holds stallreq_o until it is done.
// Optional feature macro: ROM_LAST_HIT_EN (one-entry last-read buffer; reads that hit
// complete without touching the SRAM).
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   ce_i, addr_i          request valid and byte address (word = addr_i[SRAM_AW+1:2])
//   rom_op_i, wr_data_i   0 = read/fetch, 1 = write; write data
//   inst_o                registered read result, held until the next read completes
//   stallreq_o            stall request to pipeline control
//   sram_addr_o           SRAM word address
//   sram_dq_i/_o/_oe      data from pad, data to pad, pad output enable
//   sram_ce_n/oe_n/we_n   active-low chip, output and write enables
//   sram_be_n             active-low byte enables (all on whenever the chip is enabled)
module rom_sram_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic [31:0]        addr_i,
  input  logic               rom_op_i,
  input  logic [31:0]        wr_data_i,
  output logic [31:0]        inst_o,
  output logic               stallreq_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  input  logic [31:0]        sram_dq_i,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_WR_HOLD = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int          CW        = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_CYCLES);

  logic [2:0]         state;
  logic [CW-1:0]      wait_cnt;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]        data_q;
  logic [SRAM_AW-1:0] req_word;
  logic               buf_hit;

  assign req_word = addr_i[SRAM_AW+1:2];

  // Byte-lane and segment bits of the PC address are not used by a word-wide SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:SRAM_AW+2], addr_i[1:0]};

`ifdef ROM_LAST_HIT_EN
  // inst_o always holds the word of the last completed read, so only the tag is kept.
  logic               buf_valid;
  logic [SRAM_AW-1:0] buf_tag;
  assign buf_hit = buf_valid && !rom_op_i && (buf_tag == req_word);
`else
  assign buf_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      inst_o   <= '0;
`ifdef ROM_LAST_HIT_EN
      buf_valid <= 1'b0;
      buf_tag   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ce_i) begin
            addr_q   <= req_word;
            data_q   <= wr_data_i;
            wait_cnt <= WAIT_INIT;
`ifdef ROM_LAST_HIT_EN
            if (rom_op_i) buf_valid <= 1'b0;
`endif
            if (buf_hit)       state <= S_DONE;
            else if (rom_op_i) state <= S_WRITE;
            else               state <= S_READ;
          end
        end
        S_READ: begin
          if (wait_cnt == '0) begin
            inst_o <= sram_dq_i;
            state  <= S_DONE;
`ifdef ROM_LAST_HIT_EN
            buf_valid <= 1'b1;
            buf_tag   <= addr_q;
`endif
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_WRITE: begin
          if (wait_cnt == '0) state <= S_WR_HOLD;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        S_WR_HOLD: state <= S_DONE;
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so reset drops them immediately.
  assign sram_ce_n   = !((state == S_READ) || (state == S_WRITE) || (state == S_WR_HOLD));
  assign sram_oe_n   = (state != S_READ);
  assign sram_we_n   = (state != S_WRITE);
  // Data keeps driving through WR_HOLD to give the SRAM its hold time after we_n rises.
  assign sram_dq_oe  = (state == S_WRITE) || (state == S_WR_HOLD);
  assign sram_be_n   = sram_ce_n ? 4'b1111 : 4'b0000;
  assign sram_addr_o = addr_q;
  assign sram_dq_o   = data_q;
  assign stallreq_o  = ce_i && (state != S_DONE);

endmodule
